gamepad_shifter: RTL and testbench

Parallel-in/serial-out stage between the button-mapping key controller and the Gigatron input port. It emulates a 4021-style game-controller shift register. The 8-bit active-low `key_data` byte is captured on the latch strobe and presented one bit per clock strobe on a single serial line. Strobes may arrive asynchronously from the core's sync timing, so they are synchronised and edge-detected inside the block.

---
 rtl/gamepad_shifter_if.sv | 53 +++++
 rtl/gamepad_shifter.sv | 127 ++++++++++++
 tb/tb_gamepad_shifter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/gamepad_shifter_if.sv
// -----------------------------------------------------------------------------
// gamepad_shifter_if
//
// Bundles the signals between the key controller / Gigatron input port side
// and the gamepad_shifter block.
//
// Signals:
//   key_data   : active-low button byte, WIDTH bits (master -> slave)
//   pad_latch  : level-sensitive parallel-load strobe, active-high (master -> slave)
//   pad_clk    : shift strobe, acts on its rising edge (master -> slave)
//   pad_data   : registered serial data, MSB of the shift register (slave -> master)
//   frame_done : one-cycle pulse after the WIDTH-th data bit shifts out (slave -> master)
//   bit_count  : data bits shifted since the last load, saturates at WIDTH (slave -> master)
//
// Strobe semantics (there is no valid/ready pair on this link): pad_latch and
// pad_clk are free-running, possibly asynchronous levels. A load happens on
// every cycle the synchronised latch is high. A shift happens once per
// synchronised rising edge of pad_clk, and only when the latch is low. Each
// strobe phase must last at least 2 CLOCK_50 cycles to be seen. The outputs
// are registered and are meaningful on every cycle; there is no handshake.
// -----------------------------------------------------------------------------
interface gamepad_shifter_if #(
   parameter int WIDTH = 8
);
   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] key_data;
   logic             pad_latch;
   logic             pad_clk;
   logic             pad_data;
   logic             frame_done;
   logic [CW-1:0]    bit_count;

   // Master: the side that supplies buttons and strobes.
   modport master (
      output key_data,
      output pad_latch,
      output pad_clk,
      input  pad_data,
      input  frame_done,
      input  bit_count
   );

   // Slave: the shift register itself.
   modport slave (
      input  key_data,
      input  pad_latch,
      input  pad_clk,
      output pad_data,
      output frame_done,
      output bit_count
   );
endinterface

// File: rtl/gamepad_shifter.sv
// -----------------------------------------------------------------------------
// gamepad_shifter
//
// Emulates a 4021-style game-controller shift register. The active-low
// key_data byte is captured while pad_latch is high and is then presented
// MSB first, one bit per pad_clk rising edge, on pad_data. Both strobes may
// be asynchronous to CLOCK_50, so they are synchronised and edge-detected
// here before they touch any state.
//
// Parameters:
//   WIDTH       : key bits per frame (>= 2)
//   SYNC_STAGES : synchroniser flops on pad_latch and pad_clk (>= 2)
//   FILL_BIT    : value shifted in behind the data ("not pressed")
//
// Ports:
//   CLOCK_50 : system clock, all state updates on its rising edge
//   reset    : asynchronous, active-high reset
//   pad      : gamepad_shifter_if slave modport
//              (key_data, pad_latch, pad_clk in; pad_data, frame_done,
//               bit_count out)
// -----------------------------------------------------------------------------
module gamepad_shifter #(
   parameter int   WIDTH       = 8,
   parameter int   SYNC_STAGES = 2,
   parameter logic FILL_BIT    = 1'b1
) (
   input logic               CLOCK_50,
   input logic               reset,
   gamepad_shifter_if.slave  pad
);

   localparam int CW = $clog2(WIDTH + 1);

   // Count values compared against; sized once so the compares stay width-clean.
   localparam logic [CW-1:0] COUNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] COUNT_FULL = CW'(WIDTH);
   localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

   // ---------------------------------------------------------------------------
   // Input conditioning
   // ---------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] latch_sync_q;
   logic [SYNC_STAGES-1:0] clk_sync_q;
   logic                   clk_prev_q;

   logic latch_s;
   logic clk_s;
   logic clk_rise;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         latch_sync_q <= '0;
         clk_sync_q   <= '0;
         clk_prev_q   <= 1'b0;
      end else begin
         latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], pad.pad_latch};
         clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], pad.pad_clk};
         clk_prev_q   <= clk_sync_q[SYNC_STAGES-1];
      end
   end

   assign latch_s  = latch_sync_q[SYNC_STAGES-1];
   assign clk_s    = clk_sync_q[SYNC_STAGES-1];
   // A strobe too narrow to survive the synchroniser simply never produces a
   // rise; one clean synced high phase can only ever give one rise.
   assign clk_rise = clk_s & ~clk_prev_q;

   // ---------------------------------------------------------------------------
   // Shift register, bit counter and frame-done pulse
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] sr_q;
   logic [WIDTH-1:0] sr_d;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;
   logic             done_q;
   logic             done_d;

   // Set by the first load after reset. Until then shift strobes are ignored,
   // so every output keeps its reset value until a real frame is captured.
   logic             armed_q;
   logic             armed_d;

   always_comb begin
      sr_d    = sr_q;
      count_d = count_q;
      done_d  = 1'b0;
      armed_d = armed_q;

      if (latch_s) begin
         // Reloads every cycle while the latch is high, so pad_data follows
         // key_data[WIDTH-1]. A coincident clk_rise is dropped, not queued.
         sr_d    = pad.key_data;
         count_d = '0;
         armed_d = 1'b1;
      end else if (clk_rise && armed_q) begin
         sr_d = {sr_q[WIDTH-2:0], FILL_BIT};
         if (count_q != COUNT_FULL) begin
            count_d = count_q + COUNT_ONE;
         end
         // Fires only on the transition from WIDTH-1 to WIDTH; once saturated
         // the count never equals COUNT_LAST again, so overrun cannot re-fire.
         done_d = (count_q == COUNT_LAST);
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         sr_q    <= '1;
         count_q <= '0;
         done_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         sr_q    <= sr_d;
         count_q <= count_d;
         done_q  <= done_d;
         armed_q <= armed_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs: straight from flops, no combinational path from any input.
   // ---------------------------------------------------------------------------
   assign pad.pad_data   = sr_q[WIDTH-1];
   assign pad.frame_done = done_q;
   assign pad.bit_count  = count_q;

endmodule

// File: tb/tb_gamepad_shifter.sv
// -----------------------------------------------------------------------------
// tb_gamepad_shifter
//
// Directed bench for gamepad_shifter. Driver tasks push the expected
// {pad_data, bit_count, frame_done pulse count} into exp_q; a monitor on the
// falling edge of CLOCK_50 pops and compares.
// -----------------------------------------------------------------------------
module tb_gamepad_shifter;

   localparam int WIDTH = 8;
   localparam int CW    = $clog2(WIDTH + 1);
   localparam int EW    = 1 + CW + 8;

   logic CLOCK_50;
   logic reset;

   gamepad_shifter_if #(.WIDTH(WIDTH)) pad_if ();

   gamepad_shifter #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (2),
      .FILL_BIT    (1'b1)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .pad      (pad_if)
   );

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   initial CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   logic [EW-1:0] exp_q[$];
   string         name_q[$];
   int            vectors   = 0;
   int            miscompares = 0;
   int            fd_count  = 0;   // frame_done pulses seen by the monitor
   int            fd_exp    = 0;   // frame_done pulses the bench expects so far

   always @(negedge CLOCK_50) begin
      logic [EW-1:0] e;
      logic [EW-1:0] a;
      string         nm;
      if (pad_if.frame_done === 1'b1) fd_count++;
      if (exp_q.size() > 0) begin
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         a  = {pad_if.pad_data, pad_if.bit_count, fd_count[7:0]};
         vectors++;
         if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got pad_data=%b bit_count=%0d frame_done_pulses=%0d, required pad_data=%b bit_count=%0d frame_done_pulses=%0d",
                     nm, a[EW-1], a[EW-2 -: CW], a[7:0], e[EW-1], e[EW-2 -: CW], e[7:0]);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic wait_cycles(input int n);
      repeat (n) @(posedge CLOCK_50);
      #1;
   endtask

   task automatic expect_out(input string nm, input logic pd, input int bc);
      logic [7:0] fdx;
      fdx = fd_exp[7:0];
      exp_q.push_back({pd, CW'(bc), fdx});
      name_q.push_back(nm);
      wait_cycles(1);
   endtask

   task automatic latch_pulse(input logic [WIDTH-1:0] data);
      pad_if.key_data  = data;
      pad_if.pad_latch = 1'b1;
      wait_cycles(4);
      pad_if.pad_latch = 1'b0;
      wait_cycles(4);
   endtask

   task automatic clk_pulse();
      pad_if.pad_clk = 1'b1;
      wait_cycles(4);
      pad_if.pad_clk = 1'b0;
      wait_cycles(4);
   endtask

   // Hand-computed serial sequences, MSB first.
   logic [7:0] seq_a5    [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
   logic [7:0] seq_0f    [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      reset            = 1'b1;
      pad_if.key_data  = 8'hFF;
      pad_if.pad_latch = 1'b0;
      pad_if.pad_clk   = 1'b0;

      // Reset state, held 10 cycles.
      wait_cycles(1);
      for (int i = 0; i < 10; i++) expect_out("reset_hold", 1'b1, 0);
      reset = 1'b0;
      wait_cycles(2);
      expect_out("reset_release", 1'b1, 0);

      // Basic frame 8'hA5.
      latch_pulse(8'hA5);
      expect_out("a5_load", seq_a5[0][0], 0);
      for (int k = 1; k <= 8; k++) begin
         clk_pulse();
         if (k == 8) fd_exp++;
         expect_out("a5_shift", (k < 8) ? seq_a5[k][0] : 1'b1, k);
      end

      // Overrun: fill bits, count saturated, no further frame_done.
      for (int k = 0; k < 3; k++) begin
         clk_pulse();
         expect_out("overrun", 1'b1, 8);
      end

      // Latch priority: pad_clk rises together with the latch.
      pad_if.key_data  = 8'h7E;
      pad_if.pad_latch = 1'b1;
      pad_if.pad_clk   = 1'b1;
      wait_cycles(4);
      pad_if.pad_latch = 1'b0;
      wait_cycles(4);
      pad_if.pad_clk   = 1'b0;
      wait_cycles(4);
      expect_out("latch_priority", 1'b0, 0);
      clk_pulse();
      expect_out("after_priority_shift", 1'b1, 1);

      // Snapshot isolation: key_data changes after the latch falls.
      latch_pulse(8'h0F);
      pad_if.key_data = 8'hF0;
      wait_cycles(2);
      expect_out("snap_load", seq_0f[0][0], 0);
      for (int k = 1; k <= 8; k++) begin
         clk_pulse();
         if (k == 8) fd_exp++;
         expect_out("snap_shift", (k < 8) ? seq_0f[k][0] : 1'b1, k);
      end

      // Reset mid-frame, asserted between clock edges.
      latch_pulse(8'h00);
      for (int k = 1; k <= 3; k++) begin
         clk_pulse();
         expect_out("pre_reset_shift", 1'b0, k);
      end
      @(posedge CLOCK_50);
      #3;
      reset = 1'b1;
      exp_q.push_back({1'b1, CW'(0), fd_exp[7:0]});
      name_q.push_back("async_reset");
      wait_cycles(2);
      reset = 1'b0;
      wait_cycles(2);
      for (int k = 0; k < 3; k++) begin
         clk_pulse();
         expect_out("no_latch_after_reset", 1'b1, 0);
      end

      // Drain the scoreboard, bounded.
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) wait_cycles(1);
      if (exp_q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
      end
      wait_cycles(2);
      if (fd_count != fd_exp) begin
         vectors++;
         miscompares++;
         $display("FAIL frame_done_total: got %0d pulses, required %0d", fd_count, fd_exp);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
